// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - state codes, lamp encodings and phase ring order for traffic_phase_ctrl
package traffic_pkg;

   // Fixed state codes; phase reports these values directly
   typedef enum logic [2:0] {
      RST_RED = 3'd0,
      ALL_RED = 3'd1,
      NS_G    = 3'd2,
      NS_Y    = 3'd3,
      NS_AR   = 3'd4,
      EW_G    = 3'd5,
      EW_Y    = 3'd6,
      EW_AR   = 3'd7
   } state_t;

   // Lamp group encoding {red, yellow, green}, always one-hot
   localparam logic [2:0] LAMP_R = 3'b100;
   localparam logic [2:0] LAMP_Y = 3'b010;
   localparam logic [2:0] LAMP_G = 3'b001;

   // Successor of a state on the green-yellow-all-red ring
   function automatic state_t ring_next(input state_t cur);
      case (cur)
         RST_RED: ring_next = ALL_RED;
         ALL_RED: ring_next = NS_G;
         NS_G:    ring_next = NS_Y;
         NS_Y:    ring_next = NS_AR;
         NS_AR:   ring_next = EW_G;
         EW_G:    ring_next = EW_Y;
         EW_Y:    ring_next = EW_AR;
         EW_AR:   ring_next = NS_G;
         default: ring_next = ALL_RED;
      endcase
   endfunction

endpackage

// File: rtl/tl_lamp_decode.sv
// rtl/tl_lamp_decode.sv - combinational state to NS/EW lamp decode
module tl_lamp_decode
   import traffic_pkg::*;
(
   input  state_t     state,
   output logic [2:0] ns,
   output logic [2:0] ew
);

   // Both roads red unless the state grants one road green or yellow
   always_comb begin
      ns = LAMP_R;
      ew = LAMP_R;
      case (state)
         NS_G:    ns = LAMP_G;
         NS_Y:    ns = LAMP_Y;
         EW_G:    ew = LAMP_G;
         EW_Y:    ew = LAMP_Y;
         default: ;
      endcase
   end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// rtl/traffic_phase_ctrl.sv - intersection phase sequencer; TRAFFIC_PED_REQ_EN adds the pedestrian walk path
module traffic_phase_ctrl
   import traffic_pkg::*;
#(
   parameter int W        = 6,
   parameter int G_NS     = 30,
   parameter int G_EW     = 30,
   parameter int Y_TIME   = 3,
   parameter int AR_TIME  = 2,
   parameter int PED_WALK = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         timer_done,
   input  logic         ped_req,
   output logic         timer_load,
   output logic [W-1:0] timer_len,
   output logic [2:0]   ns_lamp,
   output logic [2:0]   ew_lamp,
   output logic [2:0]   phase,
   output logic         ped_walk
);

   localparam logic [W-1:0] LEN_G_NS = W'(G_NS);
   localparam logic [W-1:0] LEN_G_EW = W'(G_EW);
   localparam logic [W-1:0] LEN_Y    = W'(Y_TIME);
   localparam logic [W-1:0] LEN_AR   = W'(AR_TIME);
   localparam logic [W-1:0] LEN_PED  = W'(PED_WALK);

   state_t       state;
   state_t       state_nxt;
   logic         enter;
   logic         clearance;
   logic         serve;
   logic [W-1:0] len_nxt;
   logic [2:0]   ns_dec;
   logic [2:0]   ew_dec;

   // Advance the ring; an expiry coincident with a load belongs to the previous phase
   always_comb begin
      state_nxt = state;
      if (state == RST_RED) begin
         state_nxt = ALL_RED;
      end else if (timer_done && !timer_load) begin
         state_nxt = ring_next(state);
      end
   end

   // The ring has no self-loops, so any change of state is an entry
   assign enter     = (state_nxt != state);
   assign clearance = (state_nxt == NS_AR) || (state_nxt == EW_AR);

   // Duration for the state being entered
   always_comb begin
      len_nxt = LEN_AR;
      case (state_nxt)
         NS_G:    len_nxt = LEN_G_NS;
         EW_G:    len_nxt = LEN_G_EW;
         NS_Y:    len_nxt = LEN_Y;
         EW_Y:    len_nxt = LEN_Y;
         default: len_nxt = serve ? LEN_PED : LEN_AR;
      endcase
   end

   // Lamps are decoded from the next state so they change together with phase
   tl_lamp_decode u_lamp_decode (
      .state (state_nxt),
      .ns    (ns_dec),
      .ew    (ew_dec)
   );

   // Main sequencer: state plus all registered status/timer outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= RST_RED;
         phase      <= RST_RED;
         timer_load <= 1'b0;
         timer_len  <= '0;
         ns_lamp    <= LAMP_R;
         ew_lamp    <= LAMP_R;
      end else begin
         state      <= state_nxt;
         phase      <= state_nxt;
         timer_load <= enter;
         ns_lamp    <= ns_dec;
         ew_lamp    <= ew_dec;
         if (enter) begin
            timer_len <= len_nxt;
         end
      end
   end

`ifdef TRAFFIC_PED_REQ_EN
   logic ped_pend;

   assign serve = enter && clearance && ped_pend;

   // Pending request latch; a request arriving as it is served re-arms it
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ped_pend <= 1'b0;
      end else if (serve) begin
         ped_pend <= ped_req;
      end else if (ped_req) begin
         ped_pend <= 1'b1;
      end
   end

   // Walk lamp lit for the whole clearance in which a request is served
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ped_walk <= 1'b0;
      end else if (enter) begin
         ped_walk <= serve;
      end
   end
`else
   logic ped_unused;

   assign serve      = 1'b0;
   assign ped_walk   = 1'b0;
   assign ped_unused = ped_req | clearance;
`endif

endmodule
